wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: the writeback stage plus the architectural integer register file.
- Selects the writeback result from the MEM/WB outputs: ALU result, load data or PC+4.
- Commits that result to x1..x31 and serves two combinational read ports to the decode stage, with internal write-to-read bypass.
- Keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, data width of registers and result path.
- NREGS, 32, number of architectural registers. x0 is hardwired to zero.
- BYPASS_EN, 1, enables same-cycle write-to-read bypass; when 0, reads return stored contents only.

Ports:
- clk_i input 1: single clock, all state updates on the rising edge.
- rst_i input 1: asynchronous, active-low reset.
- validW_i input 1: the WB slot holds a real instruction; 0 means bubble.
- regwriteW_i input 1: the instruction writes rd.
- resultsrcW_i input 2: result select. 00 = ALU, 01 = load data, 10 = PC+4, 11 = reserved.
- aluresultW_i input 32: ALU result from MEM/WB.
- readdataW_i input 32: load data from MEM/WB.
- rdW_i input 5: destination register index.
- pcplus4W_i input 32: PC+4 from MEM/WB.
- rs1D_i input 5: read port 1 index (decode).
- rs2D_i input 5: read port 2 index (decode).
- rd1D_o output 32: read port 1 data.
- rd2D_o output 32: read port 2 data.
- resultW_o output 32: selected writeback result, used for forwarding to EX.
- weW_o output 1: a register write commits at the next edge.
- instret_o output 64: retired-instruction count.

Behaviour:
- Result mux (combinational): resultW_o follows the selected source. Code 11 behaves as 00 (ALU).
- Write enable: weW_o = validW_i & regwriteW_i & (rdW_i != 0).
- Write commit: on the rising edge with weW_o = 1, reg[rdW_i] <= resultW_o. Latency is one edge.
- x0: never stored. Writes with rdW_i = 0 are dropped and weW_o stays 0.
- Reads: combinational, zero-latency.
  - rs = 0 returns 0.
  - If BYPASS_EN = 1 and weW_o = 1 and rs == rdW_i, return resultW_o; the decode stage then needs no separate WB forwarding.
  - Otherwise return reg[rs].
  - Both ports may hit the same register or both bypass simultaneously; each returns the same value.
- Retire counter: instret_o increments by 1 on each edge with validW_i = 1, independent of regwriteW_i. It wraps from 2^64-1 to 0 with no flag.
- Reset asserted (rst_i = 0), taking effect immediately:
  - all registers and instret_o clear to 0;
  - rd1D_o, rd2D_o and weW_o are forced to 0, with bypass suppressed;
  - resultW_o stays combinational.
- Reset released in the same cycle as a valid write: no write occurs at the edge where rst_i is still low. The first possible commit is the first edge with rst_i high.
- Reset mid-operation: any in-flight writeback is lost. The pipeline is expected to be flushed by the same reset.
- Bubble with regwriteW_i = 1: no write and no count. The rdW_i value is ignored.

Decomposition:
- Shared CPU package holds:
  - XLEN;
  - the result-select enum: RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;
  - the register-index width, 5.
- The enum is shared with the control unit that drives resultsrc.
- One sub-module, regfile_2r1w: storage array, x0 masking and bypass compare.
- The top level holds the result mux, write-enable logic and retire counter.

Test Plan:
- Reset with rst_i = 0 → rd1D_o = rd2D_o = 0 for all rs, instret_o = 0, weW_o = 0. Then write x5 = 0xDEADBEEF via ALU select → a next-cycle read of rs1 = 5 returns 0xDEADBEEF.
- Write x0 = 0x12345678 with valid = 1, regwrite = 1 → weW_o = 0, a read of rs1 = 0 returns 0, and instret_o increments by 1.
- Same cycle: rdW_i = 7, resultsrc = 01, readdataW_i = 0xCAFEF00D, rs1 = rs2 = 7 → both rd1D_o and rd2D_o equal 0xCAFEF00D before the edge. With BYPASS_EN = 0 both return the old x7.
- resultsrc = 10, pcplus4W_i = 0x00000104, rd = 1 → x1 = 0x104. resultsrc = 11 with aluresultW_i = 0x55 → resultW_o = 0x55.
- Bubble: validW_i = 0, regwrite = 1, rd = 3, aluresult = 0xFFFF → x3 unchanged and instret_o unchanged. Force instret_o to 2^64-1, then one valid → instret_o = 0.
- Assert rst_i low mid-cycle with weW_o = 1 → outputs clear asynchronously, no write on the following edge, x-registers read 0 after release.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions used by the writeback stage and the control unit.
package wb_regfile_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Writeback result source; encoding 2'b11 is reserved and treated as ALU.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// MEM/WB pipeline register outputs as seen by the writeback stage.
interface wb_regfile_if #(
  parameter int unsigned XLEN = wb_regfile_pkg::XLEN
);
  import wb_regfile_pkg::*;

  logic                 validW;
  logic                 regwriteW;
  logic [1:0]           resultsrcW;
  logic [XLEN-1:0]      aluresultW;
  logic [XLEN-1:0]      readdataW;
  logic [REG_IDX_W-1:0] rdW;
  logic [XLEN-1:0]      pcplus4W;

  modport master (
    output validW, regwriteW, resultsrcW, aluresultW, readdataW, rdW, pcplus4W
  );

  modport slave (
    input validW, regwriteW, resultsrcW, aluresultW, readdataW, rdW, pcplus4W
  );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_2r1w.sv
// Integer register storage: one write port, two combinational read ports,
// x0 hardwired to zero and optional write-to-read bypass.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int unsigned XLEN      = wb_regfile_pkg::XLEN,
  parameter int unsigned NREGS     = 32,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [REG_IDX_W-1:0] raddr1_i,
  input  logic [REG_IDX_W-1:0] raddr2_i,
  output logic [XLEN-1:0]      rdata1_o,
  output logic [XLEN-1:0]      rdata2_o
);

  // x0 has no storage; entries start at x1.
  logic [XLEN-1:0] regs_q [1:NREGS-1];

  // Commit one write per edge; reset clears every register immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0) && (32'(waddr_i) < NREGS)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: zero during reset or for x0, bypass the pending write, else storage.
  always_comb begin
    rdata1_o = '0;
    if (rst_i && (raddr1_i != '0) && (32'(raddr1_i) < NREGS)) begin
      if (BYPASS_EN && we_i && (raddr1_i == waddr_i)) begin
        rdata1_o = wdata_i;
      end else begin
        rdata1_o = regs_q[raddr1_i];
      end
    end
  end

  // Read port 2: same policy as port 1.
  always_comb begin
    rdata2_o = '0;
    if (rst_i && (raddr2_i != '0) && (32'(raddr2_i) < NREGS)) begin
      if (BYPASS_EN && we_i && (raddr2_i == waddr_i)) begin
        rdata2_o = wdata_i;
      end else begin
        rdata2_o = regs_q[raddr2_i];
      end
    end
  end

endmodule : regfile_2r1w

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register commit and retired-instruction count.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned XLEN      = wb_regfile_pkg::XLEN,
  parameter int unsigned NREGS     = 32,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_regfile_if.slave          memwb,
  input  logic [REG_IDX_W-1:0] rs1D_i,
  input  logic [REG_IDX_W-1:0] rs2D_i,
  output logic [XLEN-1:0]      rd1D_o,
  output logic [XLEN-1:0]      rd2D_o,
  output logic [XLEN-1:0]      resultW_o,
  output logic                 weW_o,
  output logic [63:0]          instret_o
);

  logic [63:0] instret_q;

  // Result mux; the reserved select code falls back to the ALU result.
  always_comb begin
    resultW_o = memwb.aluresultW;
    case (resultsrc_e'(memwb.resultsrcW))
      RES_MEM: resultW_o = memwb.readdataW;
      RES_PC4: resultW_o = memwb.pcplus4W;
      default: resultW_o = memwb.aluresultW;
    endcase
  end

  // Write enable: real instruction, writes rd, rd is not x0, and not in reset.
  always_comb begin
    weW_o = rst_i & memwb.validW & memwb.regwriteW & (memwb.rdW != '0);
  end

  // Retire counter counts every valid WB slot and wraps silently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instret_q <= '0;
    end else if (memwb.validW) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;

  regfile_2r1w #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .BYPASS_EN (BYPASS_EN)
  ) u_regs (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (weW_o),
    .waddr_i  (memwb.rdW),
    .wdata_i  (resultW_o),
    .raddr1_i (rs1D_i),
    .raddr2_i (rs2D_i),
    .rdata1_o (rd1D_o),
    .rdata2_o (rd2D_o)
  );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table plus corner-case sequences, with a
// scoreboard of committed register values read back at the end.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  rs1D_i, rs2D_i;
  logic [31:0] rd1D_o, rd2D_o, resultW_o;
  logic        weW_o;
  logic [63:0] instret_o;
  logic [31:0] rd1_nb, rd2_nb, result_nb;
  logic        we_nb;
  logic [63:0] instret_nb;

  always #5 clk_i = ~clk_i;

  wb_regfile_if bus ();

  wb_regfile #(.BYPASS_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .memwb(bus), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
    .rd1D_o(rd1D_o), .rd2D_o(rd2D_o), .resultW_o(resultW_o), .weW_o(weW_o),
    .instret_o(instret_o)
  );

  wb_regfile #(.BYPASS_EN(1'b0)) dut_nb (
    .clk_i(clk_i), .rst_i(rst_i), .memwb(bus), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
    .rd1D_o(rd1_nb), .rd2D_o(rd2_nb), .resultW_o(result_nb), .weW_o(we_nb),
    .instret_o(instret_nb)
  );

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_res;
    logic        exp_we;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_rd1_nb;
    logic [31:0] exp_rd2_nb;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } sb_t;

  localparam int NVEC = 9;
  vec_t        vecs [NVEC];
  sb_t         sb_q [$];
  sb_t         ent;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_instret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_bus(input logic valid, input logic rw, input logic [1:0] src,
                           input logic [31:0] alu, input logic [31:0] rdata,
                           input logic [31:0] pc4, input logic [4:0] rd);
    bus.validW     = valid;
    bus.regwriteW  = rw;
    bus.resultsrcW = src;
    bus.aluresultW = alu;
    bus.readdataW  = rdata;
    bus.pcplus4W   = pc4;
    bus.rdW        = rd;
  endtask

  task automatic sb_push(input logic [4:0] idx, input logic [31:0] val);
    for (int k = sb_q.size() - 1; k >= 0; k--) begin
      if (sb_q[k].idx == idx) sb_q.delete(k);
    end
    sb_q.push_back('{idx: idx, val: val});
  endtask

  initial begin
    //          v  rw src  alu           rdata         pc4           rd  rs1 rs2 | res           we  rd1           rd2           rd1_nb        rd2_nb
    vecs[0] = '{1, 1, 2'b00, 32'hDEADBEEF, 32'h0,        32'h0,        5,  5,  0,  32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h0,        32'h0BADF00D, 32'h0};
    vecs[1] = '{1, 1, 2'b00, 32'h12345678, 32'h0,        32'h0,        0,  0,  5,  32'h12345678, 0, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1, 2'b00, 32'h77777777, 32'h0,        32'h0,        7,  7,  5,  32'h77777777, 1, 32'h77777777, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1, 1, 2'b01, 32'h00001111, 32'hCAFEF00D, 32'h0,        7,  7,  7,  32'hCAFEF00D, 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'h77777777, 32'h77777777};
    vecs[4] = '{1, 1, 2'b10, 32'h0,        32'h0,        32'h00000104, 1,  1,  7,  32'h00000104, 1, 32'h00000104, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1, 1, 2'b11, 32'h00000055, 32'h00000099, 32'h00000088, 2,  2,  1,  32'h00000055, 1, 32'h00000055, 32'h00000104, 32'h0,        32'h00000104};
    vecs[6] = '{0, 1, 2'b00, 32'h0000FFFF, 32'h0,        32'h0,        3,  3,  2,  32'h0000FFFF, 0, 32'h0,        32'h00000055, 32'h0,        32'h00000055};
    vecs[7] = '{1, 0, 2'b00, 32'h0000AAAA, 32'h0,        32'h0,        3,  3,  3,  32'h0000AAAA, 0, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[8] = '{1, 1, 2'b00, 32'hA5A50031, 32'h0,        32'h0,        31, 31, 3,  32'hA5A50031, 1, 32'hA5A50031, 32'h0,        32'h0,        32'h0};

    // Reset held low with a valid write pending on the bus.
    rst_i = 1'b0;
    drive_bus(1'b1, 1'b1, 2'b00, 32'h0BADF00D, 32'h0, 32'h0, 5'd5);
    rs1D_i = '0;
    rs2D_i = '0;
    #1;
    for (int r = 0; r < 32; r++) begin
      rs1D_i = 5'(r);
      rs2D_i = 5'(31 - r);
      #1;
      check($sformatf("reset_rd1_x%0d", r), rd1D_o, 64'h0);
      check($sformatf("reset_rd2_x%0d", 31 - r), rd2D_o, 64'h0);
    end
    check("reset_we", weW_o, 64'h0);
    check("reset_instret", instret_o, 64'h0);
    check("reset_result_comb", resultW_o, 64'h0BADF00D);

    // Release reset in the same cycle as the pending write: first commit at next edge.
    @(negedge clk_i);
    rst_i = 1'b1;
    rs1D_i = 5'd5;
    #2;
    check("release_we", weW_o, 64'h1);
    sb_push(5'd5, 32'h0BADF00D);
    @(posedge clk_i);
    #1;
    exp_instret = 64'd1;
    check("release_instret", instret_o, exp_instret);
    @(negedge clk_i);
    drive_bus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    rs1D_i = 5'd5;
    #2;
    check("release_commit_x5", rd1D_o, 64'h0BADF00D);

    // Table-driven vectors: combinational checks before each edge, counter after.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      drive_bus(vecs[i].valid, vecs[i].regwrite, vecs[i].src, vecs[i].alu,
                vecs[i].rdata, vecs[i].pc4, vecs[i].rd);
      rs1D_i = vecs[i].rs1;
      rs2D_i = vecs[i].rs2;
      #2;
      check($sformatf("v%0d_result", i), resultW_o, vecs[i].exp_res);
      check($sformatf("v%0d_we", i), weW_o, vecs[i].exp_we);
      check($sformatf("v%0d_rd1", i), rd1D_o, vecs[i].exp_rd1);
      check($sformatf("v%0d_rd2", i), rd2D_o, vecs[i].exp_rd2);
      check($sformatf("v%0d_rd1_nobypass", i), rd1_nb, vecs[i].exp_rd1_nb);
      check($sformatf("v%0d_rd2_nobypass", i), rd2_nb, vecs[i].exp_rd2_nb);
      if (vecs[i].exp_we) sb_push(vecs[i].rd, vecs[i].exp_res);
      if (vecs[i].valid) exp_instret = exp_instret + 64'd1;
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_instret", i), instret_o, exp_instret);
    end

    // Scoreboard read-back of every register's final committed value.
    @(negedge clk_i);
    drive_bus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    while (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      @(negedge clk_i);
      rs1D_i = ent.idx;
      rs2D_i = ent.idx;
      #2;
      check($sformatf("rb_rd1_x%0d", ent.idx), rd1D_o, ent.val);
      check($sformatf("rb_rd2_x%0d", ent.idx), rd2D_o, ent.val);
      check($sformatf("rb_nobypass_x%0d", ent.idx), rd1_nb, ent.val);
    end
    rs1D_i = 5'd3;
    #1;
    check("bubble_x3_untouched", rd1D_o, 64'h0);

    // Counter wrap from all-ones to zero.
    @(negedge clk_i);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    check("wrap_preload", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_bus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    @(posedge clk_i);
    #1;
    check("wrap_to_zero", instret_o, 64'h0);

    // Asynchronous reset mid-cycle with a write in flight.
    @(negedge clk_i);
    drive_bus(1'b1, 1'b1, 2'b00, 32'h00000099, 32'h0, 32'h0, 5'd9);
    rs1D_i = 5'd9;
    rs2D_i = 5'd5;
    #2;
    check("midrst_pre_we", weW_o, 64'h1);
    check("midrst_pre_bypass", rd1D_o, 64'h99);
    rst_i = 1'b0;
    #1;
    check("midrst_we", weW_o, 64'h0);
    check("midrst_rd1", rd1D_o, 64'h0);
    check("midrst_rd2", rd2D_o, 64'h0);
    check("midrst_instret", instret_o, 64'h0);
    check("midrst_result_comb", resultW_o, 64'h99);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_bus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    #2;
    check("postrst_x9", rd1D_o, 64'h0);
    check("postrst_x5", rd2D_o, 64'h0);
    check("postrst_x9_nobypass", rd1_nb, 64'h0);
    check("postrst_instret", instret_o, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_regfile
